// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: single-outstanding instruction fetch sequencer with redirect, kill and fault.
// Define PC_FETCH_PERF_EN to build the fetch/stall performance counters.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned PC_STEP      = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_addr,
  input  logic        stall,
  output logic        fetch_fault,
  output logic [31:0] fault_addr,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_FAULT
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ipc_q, ipc_d;
  logic [31:0] faddr_q, faddr_d;
  logic        fault_q, fault_d;
  logic        kill_q, kill_d;
  logic        req_c;
  logic        redir_bad;
  logic [31:0] seq_pc;

  assign redir_bad = redirect_valid
                   & (redirect_addr[1:0] != 2'b00);
  assign seq_pc    = ipc_q + 32'(PC_STEP);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_VECTOR;
      instr_q <= '0;
      ipc_q   <= '0;
      faddr_q <= '0;
      fault_q <= 1'b0;
      kill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      faddr_q <= faddr_d;
      fault_q <= fault_d;
      kill_q  <= kill_d;
    end
  end

  // kill_q marks an in-flight response whose data must be dropped
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    faddr_d = faddr_q;
    fault_d = fault_q;
    kill_d  = kill_q;
    req_c   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
      end
      S_REQ: begin
        req_c = ~stall & ~kill_q & ~redir_bad;
        if (kill_q && imem_rvalid) begin
          kill_d = 1'b0;
        end
        if (redir_bad) begin
          fault_d = 1'b1;
          faddr_d = redirect_addr;
          state_d = S_FAULT;
        end else begin
          if (redirect_valid) begin
            pc_d = redirect_addr;
          end
          if (req_c && imem_gnt) begin
            kill_d  = redirect_valid;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          if (kill_q || redirect_valid) begin
            kill_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            instr_d = imem_rdata;
            ipc_d   = pc_q;
            state_d = S_HOLD;
          end
        end
        if (redir_bad) begin
          fault_d = 1'b1;
          faddr_d = redirect_addr;
          kill_d  = ~imem_rvalid;
          state_d = S_FAULT;
        end else if (redirect_valid) begin
          pc_d = redirect_addr;
          if (!imem_rvalid) begin
            kill_d = 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (instr_ready) begin
          if (redir_bad) begin
            fault_d = 1'b1;
            faddr_d = redirect_addr;
            state_d = S_FAULT;
          end else begin
            pc_d    = redirect_valid ? redirect_addr : seq_pc;
            state_d = S_REQ;
          end
        end
      end
      S_FAULT: begin
        if (kill_q && imem_rvalid) begin
          kill_d = 1'b0;
        end
        if (redir_bad) begin
          faddr_d = redirect_addr;
        end else if (redirect_valid) begin
          fault_d = 1'b0;
          pc_d    = redirect_addr;
          state_d = S_REQ;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign imem_req    = req_c;
  assign imem_addr   = pc_q;
  assign instr_valid = (state_q == S_HOLD);
  assign instr       = instr_q;
  assign instr_pc    = ipc_q;
  assign fetch_fault = fault_q;
  assign fault_addr  = faddr_q;

`ifdef PC_FETCH_PERF_EN
  logic [31:0] pfetch_q;
  logic [31:0] pstall_q;
  logic        hs;
  logic        stl;

  assign hs  = (state_q == S_HOLD) & instr_ready;
  assign stl = (state_q == S_REQ) & stall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pfetch_q <= '0;
      pstall_q <= '0;
    end else begin
      if (hs) begin
        pfetch_q <= pfetch_q + 32'd1;
      end
      if (stl) begin
        pstall_q <= pstall_q + 32'd1;
      end
    end
  end

  assign perf_fetch_cnt = pfetch_q;
  assign perf_stall_cnt = pstall_q;
`else
  assign perf_fetch_cnt = '0;
  assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl: directed scoreboard bench for pc_fetch_ctrl.
// Memory model answers each grant one cycle later with data derived from the address.
module tb_pc_fetch_ctrl;

`ifdef PC_FETCH_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        redirect_valid;
  logic [31:0] redirect_addr;
  logic        stall;
  logic        fetch_fault;
  logic [31:0] fault_addr;
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;

  int total;
  int bad;

  logic [31:0] exp_req[$];
  logic [31:0] exp_ins[$];

  logic        gnt_en;
  logic        rv_hold;
  logic        pend;
  logic [31:0] paddr;

  pc_fetch_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_ready   (instr_ready),
    .redirect_valid(redirect_valid),
    .redirect_addr (redirect_addr),
    .stall         (stall),
    .fetch_fault   (fetch_fault),
    .fault_addr    (fault_addr),
    .perf_fetch_cnt(perf_fetch_cnt),
    .perf_stall_cnt(perf_stall_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'hC0DE_5A5A;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic chk_req(input logic [31:0] a);
    logic [31:0] e;
    e = ~a;
    if (exp_req.size() != 0) e = exp_req.pop_front();
    chk("req_addr", a, e);
  endtask

  task automatic chk_ins();
    logic [31:0] e;
    e = ~instr_pc;
    if (exp_ins.size() != 0) e = exp_ins.pop_front();
    chk("ins_pc", instr_pc, e);
    chk("ins_data", instr, mem(e));
  endtask

  // one clock: drive memory response, grant, score, advance
  task automatic cyc();
    logic        g;
    logic [31:0] a;
    imem_rvalid = pend && !rv_hold;
    imem_rdata  = imem_rvalid ? mem(paddr) : 32'h0;
    #1;
    imem_gnt = gnt_en && imem_req;
    #1;
    g = imem_req && imem_gnt;
    a = imem_addr;
    if (g) chk_req(a);
    if (instr_valid && instr_ready) chk_ins();
    @(posedge clk);
    if (imem_rvalid) pend = 1'b0;
    if (g) begin
      pend  = 1'b1;
      paddr = a;
    end
    @(negedge clk);
  endtask

  task automatic run_until_empty(input int lim);
    int n;
    n = 0;
    while (exp_ins.size() != 0 && n < lim) begin
      cyc();
      n++;
    end
    chk("fetch_done_left", 32'(exp_ins.size()), 32'd0);
  endtask

  initial begin
    total          = 0;
    bad            = 0;
    rst            = 1'b0;
    imem_gnt       = 1'b0;
    imem_rvalid    = 1'b0;
    imem_rdata     = '0;
    instr_ready    = 1'b1;
    redirect_valid = 1'b0;
    redirect_addr  = '0;
    stall          = 1'b0;
    gnt_en         = 1'b1;
    rv_hold        = 1'b0;
    pend           = 1'b0;
    paddr          = '0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_ipc", instr_pc, 32'd0);
    chk("rst_fault", 32'(fetch_fault), 32'd0);
    chk("rst_faddr", fault_addr, 32'd0);
    chk("rst_pfetch", perf_fetch_cnt, 32'd0);
    chk("rst_pstall", perf_stall_cnt, 32'd0);

    // sequential fetch 0,4,8
    exp_req.push_back(32'h0);
    exp_req.push_back(32'h4);
    exp_req.push_back(32'h8);
    exp_ins.push_back(32'h0);
    exp_ins.push_back(32'h4);
    exp_ins.push_back(32'h8);
    rst = 1'b1;
    run_until_empty(20);
    chk("pfetch3", perf_fetch_cnt, PERF ? 32'd3 : 32'd0);

    // handshake redirect from HOLD at 0x10
    exp_req.push_back(32'hC);
    exp_ins.push_back(32'hC);
    run_until_empty(10);
    instr_ready = 1'b0;
    exp_req.push_back(32'h10);
    exp_ins.push_back(32'h10);
    cyc();
    cyc();
    chk("hold_valid", 32'(instr_valid), 32'd1);
    chk("hold_pc", instr_pc, 32'h10);
    redirect_valid = 1'b1;
    redirect_addr  = 32'h300;
    cyc();
    chk("hold_ign_valid", 32'(instr_valid), 32'd1);
    chk("hold_ign_pc", instr_pc, 32'h10);
    chk("hold_ign_data", instr, mem(32'h10));
    redirect_addr = 32'h200;
    instr_ready   = 1'b1;
    cyc();
    redirect_valid = 1'b0;
    #1;
    chk("redir_req", 32'(imem_req), 32'd1);
    chk("redir_addr", imem_addr, 32'h200);

    // REQ redirect without grant, then kill while WAIT
    gnt_en         = 1'b0;
    redirect_valid = 1'b1;
    redirect_addr  = 32'h20;
    cyc();
    redirect_valid = 1'b0;
    #1;
    chk("req_redir_addr", imem_addr, 32'h20);
    gnt_en  = 1'b1;
    rv_hold = 1'b1;
    exp_req.push_back(32'h20);
    cyc();
    redirect_valid = 1'b1;
    redirect_addr  = 32'h80;
    cyc();
    redirect_valid = 1'b0;
    rv_hold        = 1'b0;
    cyc();
    chk("kill_no_valid", 32'(instr_valid), 32'd0);
    chk("kill_next_addr", imem_addr, 32'h80);

    // misaligned redirect -> fault, then recover
    instr_ready = 1'b0;
    exp_req.push_back(32'h80);
    exp_ins.push_back(32'h80);
    cyc();
    cyc();
    instr_ready    = 1'b1;
    redirect_valid = 1'b1;
    redirect_addr  = 32'h102;
    cyc();
    redirect_valid = 1'b0;
    #1;
    chk("fault_set", 32'(fetch_fault), 32'd1);
    chk("fault_addr", fault_addr, 32'h102);
    chk("fault_noreq", 32'(imem_req), 32'd0);
    cyc();
    cyc();
    chk("fault_sticky", 32'(fetch_fault), 32'd1);
    redirect_valid = 1'b1;
    redirect_addr  = 32'h107;
    cyc();
    chk("fault_upd", fault_addr, 32'h107);
    redirect_addr = 32'h104;
    cyc();
    redirect_valid = 1'b0;
    #1;
    chk("fault_clr", 32'(fetch_fault), 32'd0);
    chk("fault_req", 32'(imem_req), 32'd1);
    chk("fault_raddr", imem_addr, 32'h104);
    exp_req.push_back(32'h104);
    exp_ins.push_back(32'h104);
    run_until_empty(10);

    // stall five cycles in REQ
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_noreq", 32'(imem_req), 32'd0);
      cyc();
    end
    chk("pstall5", perf_stall_cnt, PERF ? 32'd5 : 32'd0);
    chk("pfetch7", perf_fetch_cnt, PERF ? 32'd7 : 32'd0);
    stall = 1'b0;
    exp_req.push_back(32'h108);
    exp_ins.push_back(32'h108);
    run_until_empty(10);

    // pc wrap at top of address space
    gnt_en         = 1'b0;
    redirect_valid = 1'b1;
    redirect_addr  = 32'hFFFF_FFFC;
    cyc();
    redirect_valid = 1'b0;
    gnt_en         = 1'b1;
    exp_req.push_back(32'hFFFF_FFFC);
    exp_ins.push_back(32'hFFFF_FFFC);
    run_until_empty(10);
    #1;
    chk("wrap_addr", imem_addr, 32'h0);
    exp_req.push_back(32'h0);
    exp_ins.push_back(32'h0);
    run_until_empty(10);

    // redirect coincident with grant
    exp_req.push_back(32'h4);
    redirect_valid = 1'b1;
    redirect_addr  = 32'h40;
    cyc();
    redirect_valid = 1'b0;
    cyc();
    chk("gkill_no_valid", 32'(instr_valid), 32'd0);
    chk("gkill_addr", imem_addr, 32'h40);
    exp_req.push_back(32'h40);
    exp_ins.push_back(32'h40);
    run_until_empty(10);
    chk("pfetch11", perf_fetch_cnt, PERF ? 32'd11 : 32'd0);

    // reset during WAIT with response arriving in reset
    exp_req.push_back(32'h44);
    rv_hold = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    chk("mrst_req", 32'(imem_req), 32'd0);
    chk("mrst_valid", 32'(instr_valid), 32'd0);
    chk("mrst_instr", instr, 32'd0);
    chk("mrst_ipc", instr_pc, 32'd0);
    chk("mrst_fault", 32'(fetch_fault), 32'd0);
    chk("mrst_faddr", fault_addr, 32'd0);
    chk("mrst_pfetch", perf_fetch_cnt, 32'd0);
    chk("mrst_pstall", perf_stall_cnt, 32'd0);
    chk("mrst_addr", imem_addr, 32'h0);
    rv_hold = 1'b0;
    cyc();
    chk("mrst_rv_valid", 32'(instr_valid), 32'd0);
    chk("mrst_rv_instr", instr, 32'd0);
    rv_hold = 1'b1;
    pend    = 1'b1;
    paddr   = 32'h44;
    gnt_en  = 1'b0;
    rst     = 1'b1;
    cyc();
    rv_hold = 1'b0;
    cyc();
    cyc();
    chk("late_rv_valid", 32'(instr_valid), 32'd0);
    chk("late_rv_addr", imem_addr, 32'h0);
    gnt_en = 1'b1;
    exp_req.push_back(32'h0);
    exp_ins.push_back(32'h0);
    run_until_empty(10);
    chk("req_left", 32'(exp_req.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
